// File: rtl/vec_math_pkg.sv
// Shared constants and helpers for the fifo_math vector arithmetic stages.
// sat_clamp works on a 65-bit sign-extended value so one function serves every element width.
package vec_math_pkg;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic                 ovf;
    logic [MAX_WIDTH-1:0] value;
  } clamp_t;

  // ext_value holds a (width+1)-bit result sign-extended to MAX_WIDTH+1 bits.
  function automatic clamp_t sat_clamp(input logic [MAX_WIDTH:0] ext_value,
                                       input logic [6:0]         width);
    clamp_t               r;
    logic [MAX_WIDTH-1:0] max_pos;
    max_pos = (MAX_WIDTH'(1) << (width - 7'd1)) - MAX_WIDTH'(1);
    r.ovf   = ext_value[width] != ext_value[width - 7'd1];
    if (!r.ovf)
      r.value = ext_value[MAX_WIDTH-1:0];
    else if (ext_value[width])
      r.value = ~max_pos;
    else
      r.value = max_pos;
    return r;
  endfunction

endpackage

// File: rtl/vec_addsub_if.sv
// Operand/result bus of vec_addsub: FWFT upstream FIFO pop port and FWFT output FIFO read port.
// Handshake: x/y/op are valid while !in_empty and are taken on the edge where in_rd_en is high;
// out/out_ovf are valid while !out_empty and the head is consumed on the edge where out_rd_en is high.
interface vec_addsub_if #(
  parameter int WIDTH      = 32,
  parameter int LANES      = 3,
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [LANES-1:0][WIDTH-1:0] x;
  logic [LANES-1:0][WIDTH-1:0] y;
  logic                        op;
  logic                        in_empty;
  logic                        in_rd_en;
  logic [LANES-1:0][WIDTH-1:0] out;
  logic [LANES-1:0]            out_ovf;
  logic                        out_empty;
  logic                        out_rd_en;
  logic [CW-1:0]               out_count;

  modport master (
    output x, y, op, in_empty, out_rd_en,
    input  in_rd_en, out, out_ovf, out_empty, out_count
  );

  modport slave (
    input  x, y, op, in_empty, out_rd_en,
    output in_rd_en, out, out_ovf, out_empty, out_count
  );
endinterface

// File: rtl/fifo_array.sv
// First-word-fall-through FIFO whose entries are arrays of ARRAY_SIZE words.
// The head reads as zero while empty so downstream never sees stale storage.
module fifo_array #(
  parameter int FIFO_DATA_WIDTH  = 32,
  parameter int FIFO_BUFFER_SIZE = 16,
  parameter int ARRAY_SIZE       = 4
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       wr_en,
  input  logic [ARRAY_SIZE-1:0][FIFO_DATA_WIDTH-1:0] wr_data,
  input  logic                                       rd_en,
  output logic [ARRAY_SIZE-1:0][FIFO_DATA_WIDTH-1:0] rd_data,
  output logic                                       empty
);
   localparam int AW = $clog2(FIFO_BUFFER_SIZE);
   localparam int PW = AW + 1;

   logic [ARRAY_SIZE-1:0][FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;

   // Extra pointer bit tells full from empty when the indices match.
   assign empty = wr_ptr == rd_ptr;
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en && !full)
            wr_ptr <= wr_ptr + PW'(1);
         if (rd_en && !empty)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en && !full)
         mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/vec_addsub.sv
// Two-stage vector add/subtract with wrap or saturate, feeding an internal FWFT output FIFO.
// Pops are credit-limited so every vector in flight is guaranteed a FIFO slot.
module vec_addsub
  import vec_math_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LANES      = 3,
  parameter int FIFO_DEPTH = 16,
  parameter bit SATURATE   = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  vec_addsub_if.slave bus
);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;
   localparam int SW    = CW + 1;
   localparam int EXT_W = MAX_WIDTH + 1;

   typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

   if (LANES > WIDTH) begin : g_chk_lanes
      $error("vec_addsub: LANES must not exceed WIDTH (ovf mask rides in one element slot)");
   end
   if (WIDTH > MAX_WIDTH || WIDTH < 2) begin : g_chk_width
      $error("vec_addsub: WIDTH out of supported range");
   end
   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
      $error("vec_addsub: FIFO_DEPTH must be a power of two >= 4");
   end

   vec_t             s1_x, s1_y, s2_res, res_d;
   logic             s1_op, s1_valid, s2_valid;
   logic [LANES-1:0] s2_ovf, ovf_d;
   logic [CW-1:0]    occupancy;
   logic [SW-1:0]    in_flight;
   logic             pop, rd_fire, fifo_empty;
   clamp_t           lane_clamp [LANES];
   logic             unused_clamp_hi;
   logic             unused_ovf_pad;
   logic [LANES:0][WIDTH-1:0] wr_data, rd_data;

   // Credit covers stored vectors plus both pipeline stages.
   assign in_flight = {1'b0, occupancy} + SW'(s1_valid) + SW'(s2_valid);
   assign pop       = !reset && !bus.in_empty && (in_flight < SW'(FIFO_DEPTH));
   assign rd_fire   = bus.out_rd_en && !fifo_empty;

   always_comb begin
      logic [WIDTH:0] ext_x, ext_y, sum;
      res_d           = '0;
      ovf_d           = '0;
      unused_clamp_hi = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         ext_x         = {s1_x[i][WIDTH-1], s1_x[i]};
         ext_y         = {s1_y[i][WIDTH-1], s1_y[i]};
         sum           = (s1_op == OP_ADD) ? (ext_x + ext_y) : (ext_x - ext_y);
         lane_clamp[i] = sat_clamp(EXT_W'($signed(sum)), 7'(WIDTH));
         ovf_d[i]      = lane_clamp[i].ovf;
         res_d[i]      = SATURATE ? lane_clamp[i].value[WIDTH-1:0] : sum[WIDTH-1:0];
         unused_clamp_hi = unused_clamp_hi ^ (^lane_clamp[i].value);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_op    <= 1'b0;
         s2_valid <= 1'b0;
         s2_res   <= '0;
         s2_ovf   <= '0;
      end else begin
         s1_valid <= pop;
         if (pop) begin
            s1_x  <= bus.x;
            s1_y  <= bus.y;
            s1_op <= bus.op;
         end
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_res <= res_d;
            s2_ovf <= ovf_d;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         occupancy <= '0;
      else begin
         case ({s2_valid, rd_fire})
            2'b10:   occupancy <= occupancy + CW'(1);
            2'b01:   occupancy <= occupancy - CW'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   // Top slot carries the overflow mask, zero-extended to one element.
   always_comb begin
      wr_data             = '0;
      wr_data[LANES-1:0]  = s2_res;
      wr_data[LANES]      = WIDTH'(s2_ovf);
   end

   fifo_array #(
      .FIFO_DATA_WIDTH  (WIDTH),
      .FIFO_BUFFER_SIZE (FIFO_DEPTH),
      .ARRAY_SIZE       (LANES + 1)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (s2_valid),
      .wr_data (wr_data),
      .rd_en   (bus.out_rd_en),
      .rd_data (rd_data),
      .empty   (fifo_empty)
   );

   assign unused_ovf_pad = ^rd_data[LANES];

   assign bus.in_rd_en  = pop;
   assign bus.out       = rd_data[LANES-1:0];
   assign bus.out_ovf   = rd_data[LANES][LANES-1:0];
   assign bus.out_empty = fifo_empty;
   assign bus.out_count = occupancy;

endmodule

// File: tb/tb_vec_addsub.sv
// Self-checking bench for vec_addsub: wrap and saturate instances share one stimulus stream,
// checked every cycle against a queue model plus directed literal expectations.
module tb_vec_addsub;
  localparam int WIDTH = 32;
  localparam int LANES = 3;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam longint MAXV = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (WIDTH - 1));

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;
  typedef struct {
    vec_t x;
    vec_t y;
    logic op;
    int   ready;
  } txn_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  txn_t pend_q[$];

  vec_addsub_if #(.WIDTH(WIDTH), .LANES(LANES), .FIFO_DEPTH(DEPTH)) bus0 ();
  vec_addsub_if #(.WIDTH(WIDTH), .LANES(LANES), .FIFO_DEPTH(DEPTH)) bus1 ();

  assign bus1.x         = bus0.x;
  assign bus1.y         = bus0.y;
  assign bus1.op        = bus0.op;
  assign bus1.in_empty  = bus0.in_empty;
  assign bus1.out_rd_en = bus0.out_rd_en;

  vec_addsub #(.WIDTH(WIDTH), .LANES(LANES), .FIFO_DEPTH(DEPTH), .SATURATE(1'b0)) dut0 (
    .clock (clock), .reset (reset), .bus (bus0.slave));
  vec_addsub #(.WIDTH(WIDTH), .LANES(LANES), .FIFO_DEPTH(DEPTH), .SATURATE(1'b1)) dut1 (
    .clock (clock), .reset (reset), .bus (bus1.slave));

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2);
    vec_t v;
    v[0] = a0;
    v[1] = a1;
    v[2] = a2;
    return v;
  endfunction

  function automatic vec_t rvec();
    vec_t v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i] = 32'h7FFF_FFFF;
        1:       v[i] = 32'h8000_0000;
        2:       v[i] = 32'hFFFF_FFFF;
        3:       v[i] = 32'h0000_0001;
        default: v[i] = $urandom;
      endcase
    end
    return v;
  endfunction

  // Reference arithmetic: exact integer result, then range test against the signed limits.
  function automatic void calc(input txn_t t, input bit sat, output vec_t r, output logic [LANES-1:0] ovf);
    for (int i = 0; i < LANES; i++) begin
      longint a, b, s;
      a = longint'($signed(t.x[i]));
      b = longint'($signed(t.y[i]));
      s = t.op ? (a + b) : (a - b);
      ovf[i] = (s > MAXV) || (s < MINV);
      if (sat && s > MAXV) s = MAXV;
      else if (sat && s < MINV) s = MINV;
      r[i] = s[WIDTH-1:0];
    end
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clock) begin
    if (reset) begin
      pend_q.delete();
    end else begin
      int               vis;
      bit               exp_pop;
      vec_t             r0, r1;
      logic [LANES-1:0] o0, o1;
      txn_t             t;
      vis = 0;
      while (vis < pend_q.size() && pend_q[vis].ready <= cyc) vis++;
      chk("out_empty0", bus0.out_empty, vis == 0);
      chk("out_empty1", bus1.out_empty, vis == 0);
      chk("out_count0", bus0.out_count, vis);
      chk("out_count1", bus1.out_count, vis);
      chk("count_bound", bus0.out_count <= CW'(DEPTH), 1'b1);
      if (vis > 0) begin
        calc(pend_q[0], 1'b0, r0, o0);
        calc(pend_q[0], 1'b1, r1, o1);
        chk("out_wrap", bus0.out, r0);
        chk("ovf_wrap", bus0.out_ovf, o0);
        chk("out_sat", bus1.out, r1);
        chk("ovf_sat", bus1.out_ovf, o1);
      end
      exp_pop = !bus0.in_empty && (pend_q.size() < DEPTH);
      chk("in_rd_en0", bus0.in_rd_en, exp_pop);
      chk("in_rd_en1", bus1.in_rd_en, exp_pop);
      if (bus0.out_rd_en && vis > 0) void'(pend_q.pop_front());
      if (exp_pop) begin
        t.x = bus0.x;
        t.y = bus0.y;
        t.op = bus0.op;
        t.ready = cyc + 3;
        pend_q.push_back(t);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offers one vector and returns one time-unit after the edge that popped it.
  task automatic send(input vec_t x, input vec_t y, input logic op);
    bit got;
    got = 1'b0;
    bus0.x = x;
    bus0.y = y;
    bus0.op = op;
    bus0.in_empty = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      #1;
      got = bus0.in_rd_en;
      step();
    end
    chk("send_pop", got, 1'b1);
  endtask

  task automatic drain();
    bus0.in_empty = 1'b1;
    bus0.out_rd_en = 1'b1;
    for (int t = 0; t < 60 && !bus0.out_empty; t++) step();
    #1;
    chk("drain_empty", bus0.out_empty, 1'b1);
    bus0.out_rd_en = 1'b0;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pops;
    bus0.x = '0;
    bus0.y = '0;
    bus0.op = 1'b0;
    bus0.in_empty = 1'b1;
    bus0.out_rd_en = 1'b0;

    // Reset values, with upstream non-empty to show in_rd_en is held low.
    repeat (2) step();
    bus0.in_empty = 1'b0;
    #1;
    chk("rst_in_rd_en0", bus0.in_rd_en, 1'b0);
    chk("rst_in_rd_en1", bus1.in_rd_en, 1'b0);
    chk("rst_out_empty", bus0.out_empty, 1'b1);
    chk("rst_out_count", bus0.out_count, 0);
    chk("rst_out", bus0.out, '0);
    chk("rst_out_ovf", bus0.out_ovf, '0);
    chk("rst_out_sat", bus1.out, '0);
    bus0.in_empty = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    step();

    // Basic subtract with latency.
    send(mk(10, -5, 7), mk(3, 2, -7), 1'b0);
    bus0.in_empty = 1'b1;
    #1;
    chk("lat_n1", bus0.out_empty, 1'b1);
    step();
    chk("lat_n2", bus0.out_empty, 1'b1);
    step();
    chk("lat_n3", bus0.out_empty, 1'b0);
    chk("sub_val", bus0.out, mk(7, -7, 14));
    chk("sub_ovf", bus0.out_ovf, 3'b000);
    bus0.out_rd_en = 1'b1;
    step();
    bus0.out_rd_en = 1'b0;

    // Back-to-back alternating add/sub: a write lands every cycle.
    for (int k = 1; k <= 8; k++) begin
      send(mk(1, 2, 3), mk(4, 5, 6), (k % 2 == 1) ? 1'b1 : 1'b0);
      chk("b2b_count", bus0.out_count, (k > 2) ? k - 2 : 0);
    end
    bus0.in_empty = 1'b1;
    step();
    step();
    chk("b2b_total", bus0.out_count, 8);
    for (int j = 0; j < 8; j++) begin
      chk("b2b_order", bus0.out, (j % 2 == 0) ? mk(5, 7, 9) : mk(-3, -3, -3));
      bus0.out_rd_en = 1'b1;
      step();
    end
    bus0.out_rd_en = 1'b0;

    // Overflow in both directions, wrap and saturate instances.
    send(mk(32'h7FFF_FFFF, 32'h8000_0000, 5), mk(1, -1, 6), 1'b1);
    send(mk(32'h7FFF_FFFF, 32'h8000_0000, 5), mk(-1, 1, 6), 1'b0);
    bus0.in_empty = 1'b1;
    step();
    step();
    chk("ovf_add_wrap", bus0.out, mk(32'h8000_0000, 32'h7FFF_FFFF, 11));
    chk("ovf_add_wmask", bus0.out_ovf, 3'b011);
    chk("ovf_add_sat", bus1.out, mk(32'h7FFF_FFFF, 32'h8000_0000, 11));
    chk("ovf_add_smask", bus1.out_ovf, 3'b011);
    bus0.out_rd_en = 1'b1;
    step();
    bus0.out_rd_en = 1'b0;
    chk("ovf_sub_wrap", bus0.out, mk(32'h8000_0000, 32'h7FFF_FFFF, -1));
    chk("ovf_sub_sat", bus1.out, mk(32'h7FFF_FFFF, 32'h8000_0000, -1));
    chk("ovf_sub_smask", bus1.out_ovf, 3'b011);
    drain();

    // Backpressure: fill with no reads, then a single read buys exactly one pop.
    pops = 0;
    bus0.in_empty = 1'b0;
    for (int t = 0; t < 40; t++) begin
      bus0.x = rvec();
      bus0.y = rvec();
      bus0.op = 1'($urandom_range(0, 1));
      #1;
      if (bus0.in_rd_en) pops++;
      step();
    end
    chk("bp_pops", pops, DEPTH);
    chk("bp_count", bus0.out_count, DEPTH);
    chk("bp_stalled", bus0.in_rd_en, 1'b0);
    bus0.out_rd_en = 1'b1;
    #1;
    chk("bp_read_cycle", bus0.in_rd_en, 1'b0);
    step();
    bus0.out_rd_en = 1'b0;
    #1;
    chk("bp_reassert", bus0.in_rd_en, 1'b1);
    pops = 0;
    for (int t = 0; t < 20; t++) begin
      bus0.x = rvec();
      bus0.y = rvec();
      #1;
      if (bus0.in_rd_en) pops++;
      step();
    end
    chk("bp_one_more", pops, 1);
    chk("bp_refill", bus0.out_count, DEPTH);
    drain();

    // Random simultaneous traffic.
    for (int t = 0; t < 10000; t++) begin
      bus0.in_empty = ($urandom_range(0, 3) == 0);
      bus0.out_rd_en = 1'($urandom_range(0, 1));
      bus0.x = rvec();
      bus0.y = rvec();
      bus0.op = 1'($urandom_range(0, 1));
      step();
    end
    drain();

    // Reset with 5 stored and 2 in flight.
    for (int k = 0; k < 7; k++) send(rvec(), rvec(), 1'($urandom_range(0, 1)));
    chk("pre_rst_count", bus0.out_count, 5);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_empty0", bus0.out_empty, 1'b1);
    chk("mid_rst_empty1", bus1.out_empty, 1'b1);
    chk("mid_rst_count", bus0.out_count, 0);
    chk("mid_rst_rd_en", bus0.in_rd_en, 1'b0);
    step();
    step();
    bus0.in_empty = 1'b1;
    #1 reset = 1'b0;
    step();
    send(mk(100, 200, 300), mk(1, 2, 3), 1'b1);
    bus0.in_empty = 1'b1;
    #1;
    chk("post_rst_n1", bus0.out_empty, 1'b1);
    step();
    chk("post_rst_n2", bus0.out_empty, 1'b1);
    step();
    chk("post_rst_n3", bus0.out_empty, 1'b0);
    chk("post_rst_val", bus0.out, mk(101, 202, 303));
    chk("post_rst_count", bus0.out_count, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
